// File: rtl/store_trace_buffer.sv
// Passive store monitor on the core data bus: captures in-window stores into a
// first-word-fall-through FIFO and streams them out over valid/ready, with counters and flags.
module store_trace_buffer #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned PTR_W  = 4,
   parameter logic [31:0] WIN_LO = 32'h0000_0000,
   parameter logic [31:0] WIN_HI = 32'hFFFF_FFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      AddressData,
   input  logic [31:0]      Data_in,
   input  logic [31:0]      PC_out,
   input  logic             write_data,
   input  logic             read_data,
   input  logic             clr,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [31:0]      trace_addr,
   output logic [31:0]      trace_data,
   output logic [31:0]      trace_pc,
   output logic [PTR_W:0]   level,
   output logic [15:0]      store_cnt,
   output logic [15:0]      drop_cnt,
   output logic             overflow,
   output logic             proto_err
);

   localparam int unsigned LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [31:0]       addr_mem [DEPTH];
   logic [31:0]       data_mem [DEPTH];
   logic [31:0]       pc_mem   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  count;
   logic [31:0]       win_off;
   logic [31:0]       win_span;
   logic              in_win;
   logic              push_req;
   logic              push_ok;
   logic              pop;
   logic              drop;
   logic              full;

   // Window test as a single unsigned offset compare: lo <= a <= hi  <=>  (a - lo) <= (hi - lo)
   assign win_off  = AddressData - WIN_LO;
   assign win_span = WIN_HI - WIN_LO;
   assign in_win   = (win_off <= win_span);

   assign push_req = write_data & in_win;
   assign full     = (count == FULL_LVL);
   assign pop      = trace_valid & trace_ready;
   // A full FIFO can only accept when the head leaves in the same cycle.
   assign push_ok  = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   assign trace_valid = (count != '0);
   assign trace_addr  = trace_valid ? addr_mem[rd_ptr] : 32'h0;
   assign trace_data  = trace_valid ? data_mem[rd_ptr] : 32'h0;
   assign trace_pc    = trace_valid ? pc_mem[rd_ptr]   : 32'h0;
   assign level       = count;

   // Entry storage needs no reset; emptiness is tracked by count.
   always_ff @(posedge clk) begin
      if (!clr && push_ok) begin
         addr_mem[wr_ptr] <= AddressData;
         data_mem[wr_ptr] <= Data_in;
         pc_mem[wr_ptr]   <= PC_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         store_cnt <= 16'h0;
         drop_cnt  <= 16'h0;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         store_cnt <= 16'h0;
         drop_cnt  <= 16'h0;
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr    <= wr_ptr + 1'b1;
            store_cnt <= store_cnt + 16'h1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'h1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (write_data && read_data) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_trace_buffer.sv
// Directed bench for store_trace_buffer: vector table for single store and ordering,
// hand sequences for overflow, full push+pop, address window, flush and async reset.
module tb_store_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] AddressData, Data_in, PC_out;
   logic        write_data, read_data, clr, trace_ready;

   logic        trace_valid, w_valid;
   logic [31:0] trace_addr, trace_data, trace_pc, w_addr, w_data, w_pc;
   logic [4:0]  level, w_level;
   logic [15:0] store_cnt, drop_cnt, w_store, w_drop;
   logic        overflow, proto_err, w_ovf, w_proto;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_trace_buffer dut (
      .clk(clk), .rst_n(rst_n), .AddressData(AddressData), .Data_in(Data_in),
      .PC_out(PC_out), .write_data(write_data), .read_data(read_data), .clr(clr),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_addr(trace_addr),
      .trace_data(trace_data), .trace_pc(trace_pc), .level(level),
      .store_cnt(store_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .proto_err(proto_err)
   );

   store_trace_buffer #(.WIN_LO(32'h0000_1000), .WIN_HI(32'h0000_1FFF)) dut_w (
      .clk(clk), .rst_n(rst_n), .AddressData(AddressData), .Data_in(Data_in),
      .PC_out(PC_out), .write_data(write_data), .read_data(read_data), .clr(clr),
      .trace_valid(w_valid), .trace_ready(trace_ready), .trace_addr(w_addr),
      .trace_data(w_data), .trace_pc(w_pc), .level(w_level),
      .store_cnt(w_store), .drop_cnt(w_drop), .overflow(w_ovf), .proto_err(w_proto)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr, data, pc;
      logic        rdy;
      logic        exp_valid;
      logic [31:0] exp_addr, exp_data, exp_pc;
      logic [4:0]  exp_level;
      logic [15:0] exp_store;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p, input logic rdy);
      write_data = wr; AddressData = a; Data_in = d; PC_out = p; trace_ready = rdy;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      read_data = 1'b0;
      clr = 1'b0;
   endtask

   task automatic do_clr();
      idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      // Single store (T1), then pop, then five ordered stores (T2) drained in order.
      vecs[0] = '{1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0040_0010, 1'b0,
                  1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0040_0010, 5'd1, 16'd1};
      vecs[1] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
                  1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd1};
      for (int i = 1; i <= 5; i++)
         vecs[1+i] = '{1'b1, 32'h200 + 32'(4*i), 32'(i), 32'h0040_0000 + 32'(4*i), 1'b0,
                       1'b1, 32'h204, 32'h1, 32'h0040_0004, 5'(i), 16'(1+i)};
      for (int j = 2; j <= 5; j++)
         vecs[5+j] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
                       1'b1, 32'h200 + 32'(4*j), 32'(j), 32'h0040_0000 + 32'(4*j),
                       5'(6-j), 16'd6};
      vecs[11] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1,
                   1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 16'd6};

      rst_n = 1'b0;
      idle();
      #1;
      chk("reset_valid", 32'(trace_valid), 32'h0);
      chk("reset_level", 32'(level), 32'h0);
      chk("reset_store_cnt", 32'(store_cnt), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 12; k++) begin
         drive(vecs[k].wr, vecs[k].addr, vecs[k].data, vecs[k].pc, vecs[k].rdy);
         tick();
         chk($sformatf("vec%0d_valid", k), 32'(trace_valid), 32'(vecs[k].exp_valid));
         chk($sformatf("vec%0d_addr", k), trace_addr, vecs[k].exp_addr);
         chk($sformatf("vec%0d_data", k), trace_data, vecs[k].exp_data);
         chk($sformatf("vec%0d_pc", k), trace_pc, vecs[k].exp_pc);
         chk($sformatf("vec%0d_level", k), 32'(level), 32'(vecs[k].exp_level));
         chk($sformatf("vec%0d_store_cnt", k), 32'(store_cnt), 32'(vecs[k].exp_store));
      end

      // T3: 18 stores into a 16-deep FIFO with no consumer.
      do_clr();
      chk("clr_store_cnt", 32'(store_cnt), 32'h0);
      for (int i = 1; i <= 18; i++) begin
         drive(1'b1, 32'h300 + 32'(i), 32'h100 + 32'(i), 32'h0040_0100, 1'b0);
         tick();
      end
      idle();
      chk("ovf_level", 32'(level), 32'd16);
      chk("ovf_store_cnt", 32'(store_cnt), 32'd16);
      chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
      chk("ovf_flag", 32'(overflow), 32'h1);
      chk("ovf_head", trace_data, 32'h101);

      // T4: full, push and pop in the same cycle.
      drive(1'b1, 32'h400, 32'h200, 32'h0040_0200, 1'b1);
      tick();
      idle();
      chk("fullpp_level", 32'(level), 32'd16);
      chk("fullpp_drop_cnt", 32'(drop_cnt), 32'd2);
      chk("fullpp_store_cnt", 32'(store_cnt), 32'd17);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("drain%0d_data", k), trace_data,
             (k < 15) ? 32'h102 + 32'(k) : 32'h200);
         trace_ready = 1'b1;
         tick();
      end
      idle();
      chk("drain_valid", 32'(trace_valid), 32'h0);
      chk("drain_level", 32'(level), 32'h0);

      // T5: address window 0x1000..0x1FFF, protocol error on the 0x1000 store.
      do_clr();
      drive(1'b1, 32'h0FFC, 32'hA1, 32'h0040_0300, 1'b0); tick();
      drive(1'b1, 32'h1000, 32'hA2, 32'h0040_0304, 1'b0); read_data = 1'b1; tick();
      read_data = 1'b0;
      drive(1'b1, 32'h1FFC, 32'hA3, 32'h0040_0308, 1'b0); tick();
      drive(1'b1, 32'h2000, 32'hA4, 32'h0040_030C, 1'b0); tick();
      idle();
      chk("win_store_cnt", 32'(w_store), 32'd2);
      chk("win_level", 32'(w_level), 32'd2);
      chk("win_proto_err", 32'(w_proto), 32'h1);
      chk("win_overflow", 32'(w_ovf), 32'h0);
      chk("win_head_addr", w_addr, 32'h1000);
      chk("win_head_data", w_data, 32'hA2);
      chk("full_win_store_cnt", 32'(store_cnt), 32'd4);
      chk("full_win_proto_err", 32'(proto_err), 32'h1);
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
      chk("win_next_addr", w_addr, 32'h1FFC);
      chk("win_next_pc", w_pc, 32'h0040_0308);

      // T6: clr with a coincident store, then async reset mid-drain.
      do_clr();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h500 + 32'(4*i), 32'hC0 + 32'(i), 32'h0040_0400, 1'b0);
         tick();
      end
      idle();
      chk("pre_clr_level", 32'(level), 32'd3);
      drive(1'b1, 32'h600, 32'hBAD, 32'h0040_0500, 1'b0);
      read_data = 1'b1;
      clr = 1'b1;
      tick();
      idle();
      chk("clr_level", 32'(level), 32'h0);
      chk("clr_store", 32'(store_cnt), 32'h0);
      chk("clr_drop", 32'(drop_cnt), 32'h0);
      chk("clr_overflow", 32'(overflow), 32'h0);
      chk("clr_proto", 32'(proto_err), 32'h0);
      tick();
      chk("clr_no_store_level", 32'(level), 32'h0);
      chk("clr_no_store_valid", 32'(trace_valid), 32'h0);

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h700 + 32'(4*i), 32'hE0 + 32'(i), 32'h0040_0600, 1'b0);
         tick();
      end
      trace_ready = 1'b1;
      write_data = 1'b0;
      tick();
      chk("middrain_level", 32'(level), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(trace_valid), 32'h0);
      chk("async_level", 32'(level), 32'h0);
      chk("async_data", trace_data, 32'h0);
      chk("async_addr", trace_addr, 32'h0);
      chk("async_pc", trace_pc, 32'h0);
      chk("async_store", 32'(store_cnt), 32'h0);
      idle();
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_reset_level", 32'(level), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
